// File: rtl/ex_dmem_req_pkg.sv
// ============================================================================
// Module : ex_dmem_req_pkg
// Brief  : Shared size/state encodings for the EX data-memory request slice.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package ex_dmem_req_pkg;

    localparam int MAX_OUTST_DEFAULT = 2;

    localparam logic [1:0] C_SIZE_BYTE = 2'd0;
    localparam logic [1:0] C_SIZE_HALF = 2'd1;
    localparam logic [1:0] C_SIZE_WORD = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_ADDR = 2'd1,
        ST_HOLD      = 2'd2
    } state_e;

endpackage

`default_nettype wire

// File: rtl/ex_dmem_req_if.sv
// ============================================================================
// Module : ex_dmem_req_if
// Brief  : SRAM-like data bus (req/addr_ok request, data_ok response).
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface ex_dmem_req_if;
    logic        data_sram_req;
    logic        data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [3:0]  data_sram_wstrb;
    logic        data_sram_addr_ok;
    logic        data_sram_data_ok;

    modport master (
        output data_sram_req, data_sram_wr, data_sram_size,
               data_sram_addr, data_sram_wdata, data_sram_wstrb,
        input  data_sram_addr_ok, data_sram_data_ok
    );

    modport slave (
        input  data_sram_req, data_sram_wr, data_sram_size,
               data_sram_addr, data_sram_wdata, data_sram_wstrb,
        output data_sram_addr_ok, data_sram_data_ok
    );
endinterface

`default_nettype wire

// File: rtl/ex_dmem_req_store_align.sv
// ============================================================================
// Module : ex_dmem_req_store_align
// Brief  : Store byte-lane strobe, replicated store data and alignment check.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ex_dmem_req_store_align
    import ex_dmem_req_pkg::*;
(
    input  wire logic [1:0]  size,
    input  wire logic [1:0]  offset,
    input  wire logic [31:0] wdata,
    output logic      [3:0]  wstrb,
    output logic      [31:0] wdata_aligned,
    output logic             ale
);

    always_comb begin
        wstrb         = 4'b0000;
        wdata_aligned = wdata;
        ale           = 1'b0;
        case (size)
            C_SIZE_BYTE: begin
                wstrb         = 4'b0001 << offset;
                wdata_aligned = {4{wdata[7:0]}};
            end
            C_SIZE_HALF: begin
                wstrb         = offset[1] ? 4'b1100 : 4'b0011;
                wdata_aligned = {2{wdata[15:0]}};
                ale           = offset[0];
            end
            C_SIZE_WORD: begin
                wstrb         = 4'b1111;
                ale           = (offset != 2'b00);
            end
            default: begin
                wstrb         = 4'b0000;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/ex_dmem_req.sv
// ============================================================================
// Module : ex_dmem_req
// Brief  : EX-stage data request issue with one-entry skid to MEM and
//          suppression of data_ok responses that belong to flushed ops.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ex_dmem_req
    import ex_dmem_req_pkg::*;
#(
    parameter int MAX_OUTST = MAX_OUTST_DEFAULT
)(
    input  wire logic        clk,
    input  wire logic        resetn,
    input  wire logic        in_valid,
    output logic             in_ready,
    input  wire logic        in_ld,
    input  wire logic        in_st,
    input  wire logic [1:0]  in_size,
    input  wire logic [31:0] in_addr,
    input  wire logic [31:0] in_wdata,
    input  wire logic        cancel,
    input  wire logic        ms_has_exc,
    ex_dmem_req_if.master    bus,
    output logic             out_valid,
    input  wire logic        out_ready,
    output logic             out_req_sent,
    output logic             out_ale,
    output logic      [1:0]  out_offset,
    output logic             ms_data_ok
);

    localparam int C_CNT_W = $clog2(MAX_OUTST + 1);
    typedef logic [C_CNT_W-1:0] cnt_t;
    localparam cnt_t C_MAX = cnt_t'(MAX_OUTST);

    state_e      state_q,    state_d;
    logic        st_q,       st_d;
    logic [1:0]  size_q,     size_d;
    logic [31:0] addr_q,     addr_d;
    logic [31:0] wdata_q,    wdata_d;
    logic [3:0]  wstrb_q,    wstrb_d;
    logic        ale_q,      ale_d;
    logic        req_sent_q, req_sent_d;
    logic        killed_q,   killed_d;
    cnt_t        outst_q,    outst_d;
    cnt_t        orphan_q,   orphan_d;

    logic [3:0]  w_strb;
    logic [31:0] w_wdata_al;
    logic        w_ale;
    logic        w_is_mem;
    logic        w_accept;
    logic        w_issue;

    ex_dmem_req_store_align u_align (
        .size          (in_size),
        .offset        (in_addr[1:0]),
        .wdata         (in_wdata),
        .wstrb         (w_strb),
        .wdata_aligned (w_wdata_al),
        .ale           (w_ale)
    );

    // A response freeing a slot lets the waiting request go in the same cycle.
    assign bus.data_sram_req   = (state_q == ST_WAIT_ADDR) &
                                 ((outst_q < C_MAX) | bus.data_sram_data_ok);
    assign bus.data_sram_wr    = st_q;
    assign bus.data_sram_size  = size_q;
    assign bus.data_sram_addr  = addr_q;
    assign bus.data_sram_wdata = wdata_q;
    assign bus.data_sram_wstrb = wstrb_q;

    assign w_is_mem  = in_ld | in_st;
    assign in_ready  = (state_q == ST_IDLE) |
                       ((state_q == ST_HOLD) & out_ready & ~cancel);
    assign w_accept  = in_valid & in_ready;
    assign w_issue   = bus.data_sram_req & bus.data_sram_addr_ok;

    assign out_valid    = (state_q == ST_HOLD) & ~cancel;
    assign out_req_sent = req_sent_q;
    assign out_ale      = ale_q;
    assign out_offset   = addr_q[1:0];
    assign ms_data_ok   = bus.data_sram_data_ok & ~cancel & (orphan_q == '0);

    always_comb begin
        state_d    = state_q;
        st_d       = st_q;
        size_d     = size_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        ale_d      = ale_q;
        req_sent_d = req_sent_q;
        killed_d   = killed_q;

        case (state_q)
            ST_IDLE: begin
                state_d = ST_IDLE;
            end
            ST_WAIT_ADDR: begin
                if (w_issue) begin
                    killed_d   = 1'b0;
                    req_sent_d = 1'b1;
                    state_d    = (killed_q | cancel) ? ST_IDLE : ST_HOLD;
                end else if (cancel) begin
                    killed_d   = 1'b1;
                end
            end
            ST_HOLD: begin
                if (cancel || out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // An op accepted in the same cycle as a flush is dropped.
        if (w_accept && !cancel) begin
            st_d       = in_st;
            size_d     = in_size;
            addr_d     = in_addr;
            wdata_d    = w_wdata_al;
            wstrb_d    = in_st ? w_strb : 4'b0000;
            ale_d      = w_is_mem & w_ale;
            req_sent_d = 1'b0;
            killed_d   = 1'b0;
            state_d    = (w_is_mem && !w_ale && !ms_has_exc) ? ST_WAIT_ADDR : ST_HOLD;
        end
    end

    always_comb begin
        outst_d = outst_q + cnt_t'(w_issue) - cnt_t'(bus.data_sram_data_ok);
        if (cancel) begin
            orphan_d = outst_d;
        end else begin
            orphan_d = orphan_q + cnt_t'(w_issue & killed_q)
                     - cnt_t'(bus.data_sram_data_ok & (orphan_q != '0));
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            st_q       <= 1'b0;
            size_q     <= 2'b00;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            wstrb_q    <= 4'b0000;
            ale_q      <= 1'b0;
            req_sent_q <= 1'b0;
            killed_q   <= 1'b0;
            outst_q    <= '0;
            orphan_q   <= '0;
        end else begin
            state_q    <= state_d;
            st_q       <= st_d;
            size_q     <= size_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            ale_q      <= ale_d;
            req_sent_q <= req_sent_d;
            killed_q   <= killed_d;
            outst_q    <= outst_d;
            orphan_q   <= orphan_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ex_dmem_req.sv
// ============================================================================
// Module : tb_ex_dmem_req
// Brief  : Directed vector table plus flush/outstanding corner sequences.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_ex_dmem_req;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_ld = 1'b0;
    logic        in_st = 1'b0;
    logic [1:0]  in_size = 2'd0;
    logic [31:0] in_addr = 32'h0;
    logic [31:0] in_wdata = 32'h0;
    logic        cancel = 1'b0;
    logic        ms_has_exc = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        out_req_sent;
    logic        out_ale;
    logic [1:0]  out_offset;
    logic        ms_data_ok;

    int n_checks = 0;
    int n_err    = 0;

    ex_dmem_req_if bus ();

    ex_dmem_req #(.MAX_OUTST(2)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_ld        (in_ld),
        .in_st        (in_st),
        .in_size      (in_size),
        .in_addr      (in_addr),
        .in_wdata     (in_wdata),
        .cancel       (cancel),
        .ms_has_exc   (ms_has_exc),
        .bus          (bus),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_req_sent (out_req_sent),
        .out_ale      (out_ale),
        .out_offset   (out_offset),
        .ms_data_ok   (ms_data_ok)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ld;
        logic        st;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exc;
        logic        exp_req;
        logic [3:0]  exp_wstrb;
        logic [31:0] exp_wdata;
        logic        exp_ale;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic accept(input logic ld, input logic st, input logic [1:0] size,
                          input logic [31:0] addr, input logic [31:0] wdata, input logic exc);
        in_valid   = 1'b1;
        in_ld      = ld;
        in_st      = st;
        in_size    = size;
        in_addr    = addr;
        in_wdata   = wdata;
        ms_has_exc = exc;
        step();
        in_valid   = 1'b0;
        in_ld      = 1'b0;
        in_st      = 1'b0;
        ms_has_exc = 1'b0;
        #1;
    endtask

    // Load issued and drained to MEM; its data_ok is left outstanding.
    task automatic issue_load(input logic [31:0] addr);
        accept(1'b1, 1'b0, 2'd2, addr, 32'h0, 1'b0);
        bus.data_sram_addr_ok = 1'b1;
        step();
        bus.data_sram_addr_ok = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic resp(input string name, input logic exp_fwd);
        bus.data_sram_data_ok = 1'b1;
        #1;
        chk(name, 32'(ms_data_ok), 32'(exp_fwd));
        step();
        bus.data_sram_data_ok = 1'b0;
    endtask

    initial begin
        bus.data_sram_addr_ok = 1'b0;
        bus.data_sram_data_ok = 1'b0;

        //        ld   st   size  addr          wdata         exc  req  wstrb    exp_wdata     ale
        vecs[0]  = '{1'b0, 1'b1, 2'd0, 32'h0000_1003, 32'h1234_56AB, 1'b0, 1'b1, 4'b1000, 32'hABAB_ABAB, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 2'd1, 32'h0000_2002, 32'h1234_BEEF, 1'b0, 1'b1, 4'b1100, 32'hBEEF_BEEF, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 2'd2, 32'h0000_3000, 32'hDEAD_BEEF, 1'b0, 1'b1, 4'b1111, 32'hDEAD_BEEF, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 2'd2, 32'h0000_1002, 32'h0,         1'b0, 1'b0, 4'b0000, 32'h0,         1'b1};
        vecs[4]  = '{1'b1, 1'b0, 2'd1, 32'h0000_1001, 32'h0,         1'b0, 1'b0, 4'b0000, 32'h0,         1'b1};
        vecs[5]  = '{1'b1, 1'b0, 2'd2, 32'h0000_4004, 32'h0,         1'b0, 1'b1, 4'b0000, 32'h0,         1'b0};
        vecs[6]  = '{1'b0, 1'b1, 2'd2, 32'h0000_5000, 32'h1111_2222, 1'b1, 1'b0, 4'b0000, 32'h0,         1'b0};
        vecs[7]  = '{1'b0, 1'b0, 2'd2, 32'h0000_6003, 32'h0,         1'b0, 1'b0, 4'b0000, 32'h0,         1'b0};
        vecs[8]  = '{1'b0, 1'b1, 2'd1, 32'h0000_7001, 32'h0000_5555, 1'b0, 1'b0, 4'b0000, 32'h0,         1'b1};
        vecs[9]  = '{1'b1, 1'b0, 2'd0, 32'h0000_8001, 32'h0,         1'b0, 1'b1, 4'b0000, 32'h0,         1'b0};
        vecs[10] = '{1'b0, 1'b1, 2'd0, 32'h0000_1000, 32'h0000_0077, 1'b0, 1'b1, 4'b0001, 32'h7777_7777, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 2'd1, 32'h0000_1000, 32'h0000_CAFE, 1'b0, 1'b1, 4'b0011, 32'hCAFE_CAFE, 1'b0};

        // Reset state
        @(negedge clk);
        #1;
        chk("rst_in_ready",  32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_req",       32'(bus.data_sram_req), 32'd0);
        chk("rst_wstrb",     32'(bus.data_sram_wstrb), 32'd0);
        chk("rst_ms_data_ok", 32'(ms_data_ok), 32'd0);
        step();
        resetn = 1'b1;
        step();

        for (int i = 0; i < 12; i++) begin
            accept(vecs[i].ld, vecs[i].st, vecs[i].size, vecs[i].addr, vecs[i].wdata, vecs[i].exc);
            chk($sformatf("v%0d_req", i), 32'(bus.data_sram_req), 32'(vecs[i].exp_req));
            if (vecs[i].exp_req) begin
                chk($sformatf("v%0d_wr", i),    32'(bus.data_sram_wr), 32'(vecs[i].st));
                chk($sformatf("v%0d_addr", i),  bus.data_sram_addr, vecs[i].addr);
                chk($sformatf("v%0d_wstrb", i), 32'(bus.data_sram_wstrb), 32'(vecs[i].exp_wstrb));
                if (vecs[i].st)
                    chk($sformatf("v%0d_wdata", i), bus.data_sram_wdata, vecs[i].exp_wdata);
                chk($sformatf("v%0d_early_valid", i), 32'(out_valid), 32'd0);
                bus.data_sram_addr_ok = 1'b1;
                step();
                bus.data_sram_addr_ok = 1'b0;
            end
            chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("v%0d_req_sent", i),  32'(out_req_sent), 32'(vecs[i].exp_req));
            chk($sformatf("v%0d_ale", i),       32'(out_ale), 32'(vecs[i].exp_ale));
            chk($sformatf("v%0d_offset", i),    32'(out_offset), 32'(vecs[i].addr[1:0]));
            out_ready = 1'b1;
            if (vecs[i].exp_req) begin
                resp($sformatf("v%0d_resp", i), 1'b1);
            end else begin
                step();
            end
            out_ready = 1'b0;
            chk($sformatf("v%0d_drained", i), 32'(out_valid), 32'd0);
        end

        // Two outstanding loads: third request held until a response frees a slot
        issue_load(32'h100);
        issue_load(32'h104);
        accept(1'b1, 1'b0, 2'd2, 32'h108, 32'h0, 1'b0);
        chk("full_req_low0", 32'(bus.data_sram_req), 32'd0);
        step();
        chk("full_req_low1", 32'(bus.data_sram_req), 32'd0);
        bus.data_sram_data_ok = 1'b1;
        #1;
        chk("full_req_on_data_ok", 32'(bus.data_sram_req), 32'd1);
        chk("full_fwd_data_ok",    32'(ms_data_ok), 32'd1);
        step();
        bus.data_sram_data_ok = 1'b0;
        #1;
        chk("full_req_held", 32'(bus.data_sram_req), 32'd1);
        chk("full_addr",     bus.data_sram_addr, 32'h108);
        bus.data_sram_addr_ok = 1'b1;
        step();
        bus.data_sram_addr_ok = 1'b0;
        chk("full_out_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        resp("full_resp2", 1'b1);
        resp("full_resp3", 1'b1);

        // Back-to-back: HOLD hands over to a new request in one cycle
        accept(1'b1, 1'b0, 2'd2, 32'h200, 32'h0, 1'b0);
        bus.data_sram_addr_ok = 1'b1;
        step();
        bus.data_sram_addr_ok = 1'b0;
        out_ready = 1'b1;
        in_valid = 1'b1; in_ld = 1'b1; in_size = 2'd2; in_addr = 32'h304;
        #1;
        chk("b2b_in_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0; in_ld = 1'b0; out_ready = 1'b0;
        #1;
        chk("b2b_req",  32'(bus.data_sram_req), 32'd1);
        chk("b2b_addr", bus.data_sram_addr, 32'h304);
        bus.data_sram_addr_ok = 1'b1;
        step();
        bus.data_sram_addr_ok = 1'b0;
        chk("b2b_out_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        resp("b2b_resp0", 1'b1);
        resp("b2b_resp1", 1'b1);

        // Cancel while waiting for addr_ok: request stays up, its response is dropped
        accept(1'b1, 1'b0, 2'd2, 32'h400, 32'h0, 1'b0);
        chk("kill_req", 32'(bus.data_sram_req), 32'd1);
        cancel = 1'b1;
        #1;
        chk("kill_req_during_cancel", 32'(bus.data_sram_req), 32'd1);
        step();
        cancel = 1'b0;
        #1;
        chk("kill_req_held", 32'(bus.data_sram_req), 32'd1);
        step();
        step();
        bus.data_sram_addr_ok = 1'b1;
        step();
        bus.data_sram_addr_ok = 1'b0;
        chk("kill_no_valid", 32'(out_valid), 32'd0);
        chk("kill_idle",     32'(in_ready), 32'd1);
        chk("kill_req_gone", 32'(bus.data_sram_req), 32'd0);
        resp("kill_resp_dropped", 1'b0);
        issue_load(32'h404);
        resp("kill_next_resp_fwd", 1'b1);

        // Cancel with two outstanding and a coincident response
        issue_load(32'h500);
        issue_load(32'h504);
        cancel = 1'b1;
        bus.data_sram_data_ok = 1'b1;
        #1;
        chk("orph_same_cycle", 32'(ms_data_ok), 32'd0);
        step();
        cancel = 1'b0;
        bus.data_sram_data_ok = 1'b0;
        resp("orph_second", 1'b0);
        issue_load(32'h508);
        issue_load(32'h50C);
        accept(1'b1, 1'b0, 2'd2, 32'h510, 32'h0, 1'b0);
        chk("orph_outst_full", 32'(bus.data_sram_req), 32'd0);
        resp("orph_live0", 1'b1);
        bus.data_sram_addr_ok = 1'b1;
        step();
        bus.data_sram_addr_ok = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        resp("orph_live1", 1'b1);
        resp("orph_live2", 1'b1);

        // Reset while a store waits for addr_ok
        accept(1'b0, 1'b1, 2'd2, 32'h600, 32'h1234_5678, 1'b0);
        chk("mid_req", 32'(bus.data_sram_req), 32'd1);
        resetn = 1'b0;
        #1;
        chk("mid_rst_req",      32'(bus.data_sram_req), 32'd0);
        chk("mid_rst_wr",       32'(bus.data_sram_wr), 32'd0);
        chk("mid_rst_addr",     bus.data_sram_addr, 32'h0);
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        step();
        resetn = 1'b1;
        step();
        issue_load(32'h700);
        resp("post_rst_resp", 1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
